// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant,
// release on done / owner drop / hold timeout, and a dead cycle between grants.
module rr_grant_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16,
    parameter int CW       = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic [2:0]   last_idx,
    output logic         timeout
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] hold_cnt;
    logic          sel_found;
    logic [2:0]    sel_idx;
    logic [2:0]    cand;
    logic          owner_drop;
    logic          hold_hit;

    // Search upward from last_idx+1; the 3-bit add wraps 7->0 naturally.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = last_idx;
        cand      = last_idx;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = last_idx + 3'(k);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign owner_drop = !req[last_idx];
    assign hold_hit   = (hold_cnt == CW'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            last_idx  <= 3'd7;
            hold_cnt  <= '0;
            timeout   <= 1'b0;
        end else if (state == IDLE) begin
            timeout <= 1'b0;
            if (sel_found) begin
                gnt       <= {{(N-1){1'b0}}, 1'b1} << sel_idx;
                gnt_valid <= 1'b1;
                last_idx  <= sel_idx;
                hold_cnt  <= '0;
                state     <= GRANT;
            end
        end else begin
            if (done || owner_drop || hold_hit) begin
                gnt       <= '0;
                gnt_valid <= 1'b0;
                hold_cnt  <= '0;
                state     <= IDLE;
                // Flag a timeout only when the hold limit alone forced the release.
                timeout   <= hold_hit && !done && !owner_drop;
            end else begin
                hold_cnt <= hold_cnt + CW'(1);
                timeout  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed self-checking bench for rr_grant_arbiter (MAX_HOLD=4 instance).
module tb_rr_grant_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] last_idx;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_gnt [3];
    logic [2:0] exp_idx [3];

    rr_grant_arbiter #(.N(8), .MAX_HOLD(4), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .last_idx  (last_idx),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        #1;
        check("rst_gnt", gnt, 8'h00);
        check("rst_valid", gnt_valid, 1'b0);
        check("rst_last_idx", last_idx, 3'd7);
        check("rst_timeout", timeout, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Structural invariants sampled mid-cycle throughout the run.
    always @(negedge clk) begin
        check("inv_valid", gnt_valid, |gnt);
        check("inv_onehot0", $onehot0(gnt), 1'b1);
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        tick();
        do_reset();
        tick();
        check("idle_gnt", gnt, 8'h00);

        // First grant after reset goes to requester 0 in one cycle.
        req = 8'h01;
        tick();
        check("t1_gnt", gnt, 8'h01);
        check("t1_valid", gnt_valid, 1'b1);
        check("t1_last_idx", last_idx, 3'd0);

        // Owner drops its request: release on the next edge, no timeout.
        req = 8'h00;
        tick();
        check("drop_gnt", gnt, 8'h00);
        check("drop_timeout", timeout, 1'b0);

        // Alternation between requesters 0 and 7 with done after 3 cycles.
        do_reset();
        exp_gnt[0] = 8'h01; exp_idx[0] = 3'd0;
        exp_gnt[1] = 8'h80; exp_idx[1] = 3'd7;
        exp_gnt[2] = 8'h01; exp_idx[2] = 3'd0;
        req = 8'h81;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("alt_gnt", gnt, exp_gnt[i]);
            check("alt_last_idx", last_idx, exp_idx[i]);
            tick();
            check("alt_hold", gnt, exp_gnt[i]);
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            check("alt_gap", gnt, 8'h00);
            check("alt_gap_timeout", timeout, 1'b0);
        end

        // Wrap-around: last_idx=6, then 0x43 must pick bit 0, not bit 1.
        req = 8'h40;
        tick();
        check("wrap_prime", gnt, 8'h40);
        check("wrap_prime_idx", last_idx, 3'd6);
        req  = 8'h43;
        done = 1'b1;
        tick();
        done = 1'b0;
        check("wrap_gap", gnt, 8'h00);
        tick();
        check("wrap_gnt", gnt, 8'h01);
        check("wrap_last_idx", last_idx, 3'd0);

        // Timeout: held 4 cycles, one-cycle timeout pulse, then re-grant.
        req = 8'h04;
        tick();
        check("to_release_prev", gnt, 8'h00);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("to_hold_gnt", gnt, 8'h04);
            check("to_hold_timeout", timeout, 1'b0);
            tick();
        end
        check("to_gnt", gnt, 8'h00);
        check("to_valid", gnt_valid, 1'b0);
        check("to_pulse", timeout, 1'b1);
        tick();
        check("to_regrant", gnt, 8'h04);
        check("to_pulse_end", timeout, 1'b0);

        // done coincides with the hold limit: release without timeout.
        tick();
        tick();
        tick();
        check("sim_hold", gnt, 8'h04);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("sim_gnt", gnt, 8'h00);
        check("sim_timeout", timeout, 1'b0);

        // done in IDLE is ignored.
        req  = 8'h00;
        tick();
        check("idle_empty", gnt, 8'h00);
        req  = 8'h10;
        done = 1'b1;
        tick();
        done = 1'b0;
        check("idle_done_gnt", gnt, 8'h10);
        check("idle_done_idx", last_idx, 3'd4);

        // Asynchronous reset mid-grant.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gnt", gnt, 8'h00);
        check("async_valid", gnt_valid, 1'b0);
        check("async_last_idx", last_idx, 3'd7);
        tick();
        rst_n = 1'b1;
        req   = 8'hFF;
        tick();
        check("post_rst_gnt", gnt, 8'h01);
        check("post_rst_idx", last_idx, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
